// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle
//
// Groups the pipeline-side hazard inputs and the stall/flush controls.
// slave  : the hazard controller (consumes hazard info, drives controls).
// master : the pipeline / environment (drives hazard info, consumes controls).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard information from the pipeline
  logic             idex_memRead;
  logic             idex_mulDiv;
  logic [3:0]       idex_regDes;
  logic [3:0]       ifid_rs1;
  logic [3:0]       ifid_rs2;
  logic             ifid_useRs1;
  logic             ifid_useRs2;
  logic             branch_taken;
  logic             ifid_halt;
  // controls back into the pipeline buffers and PC
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_start;
  logic             md_busy;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  idex_memRead, idex_mulDiv, idex_regDes, ifid_rs1, ifid_rs2,
           ifid_useRs1, ifid_useRs2, branch_taken, ifid_halt,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_flush, md_start, md_busy, halted, stall_cycles
  );

  modport master (
    output idex_memRead, idex_mulDiv, idex_regDes, ifid_rs1, ifid_rs2,
           ifid_useRs1, ifid_useRs2, branch_taken, ifid_halt,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_flush, md_start, md_busy, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipeline_hazard_ctrl_if.slave
//          inputs  - load/mul-div/dest info of EX, source regs of ID,
//                    branch_taken, ifid_halt
//          outputs - pc/ifid/idex write enables, ifid/idex/exmem flushes,
//                    md_start/md_busy, halted, saturating stall_cycles
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic exmem_flush, md_start, md_busy;
  logic load_use;

  assign load_use = bus.idex_memRead &&
                    ((bus.ifid_useRs1 && (bus.ifid_rs1 == bus.idex_regDes)) ||
                     (bus.ifid_useRs2 && (bus.ifid_rs2 == bus.idex_regDes)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_start    = 1'b0;
    md_busy     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_RUN: begin
        if (bus.branch_taken) begin
          // squash the two younger instructions; PC takes the target
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (bus.idex_mulDiv) begin
          md_start    = 1'b1;
          md_busy     = 1'b1;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
          // entry cycle is the first stall, release cycle is the last EX cycle
          cnt_d       = 4'(MD_LATENCY - 2);
          state_d     = ST_MD_WAIT;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else if (bus.ifid_halt) begin
          // halt advances out of ID but never reaches EX
          idex_flush = 1'b1;
          state_d    = ST_HALT;
        end
      end
      ST_MD_WAIT: begin
        md_busy = 1'b1;
        if (cnt_q != 4'd0) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
          cnt_d       = cnt_q - 4'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    halted_d = halted_q || (state_d == ST_HALT);

    // halt is a terminal condition, not a performance stall
    if (!pc_write && (state_q != ST_HALT) && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
    else
      stall_d = stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_write   = idex_write;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.md_start     = md_start;
  assign bus.md_busy      = md_busy;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  assign bus4.idex_memRead = bus.idex_memRead;
  assign bus4.idex_mulDiv  = bus.idex_mulDiv;
  assign bus4.idex_regDes  = bus.idex_regDes;
  assign bus4.ifid_rs1     = bus.ifid_rs1;
  assign bus4.ifid_rs2     = bus.ifid_rs2;
  assign bus4.ifid_useRs1  = bus.ifid_useRs1;
  assign bus4.ifid_useRs2  = bus.ifid_useRs2;
  assign bus4.branch_taken = bus.branch_taken;
  assign bus4.ifid_halt    = bus.ifid_halt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    // inputs
    logic       mem_read;
    logic       mul_div;
    logic [3:0] reg_des;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       use1;
    logic       use2;
    logic       branch;
    logic       halt;
    // expected: pc_write ifid_write ifid_flush idex_write idex_flush exmem_flush md_start md_busy
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_vec();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
            bus.idex_flush, bus.exmem_flush, bus.md_start, bus.md_busy};
  endfunction

  task automatic clear_inputs();
    bus.idex_memRead = 1'b0;
    bus.idex_mulDiv  = 1'b0;
    bus.idex_regDes  = 4'h0;
    bus.ifid_rs1     = 4'h0;
    bus.ifid_rs2     = 4'h0;
    bus.ifid_useRs1  = 1'b0;
    bus.ifid_useRs2  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ifid_halt    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_load_use();
    bus.idex_memRead = 1'b1;
    bus.idex_regDes  = 4'h3;
    bus.ifid_rs1     = 4'h3;
    bus.ifid_useRs1  = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();

    //            mr   md   des   rs1   rs2   u1   u2   br   ht   expected
    vecs[0]  = '{1'b0,1'b0,4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,1'b0,8'b1101_0000};
    vecs[1]  = '{1'b1,1'b0,4'h3,4'h3,4'h0,1'b1,1'b0,1'b0,1'b0,8'b0001_1000};
    vecs[2]  = '{1'b1,1'b0,4'h7,4'h1,4'h7,1'b0,1'b1,1'b0,1'b0,8'b0001_1000};
    vecs[3]  = '{1'b1,1'b0,4'h3,4'h3,4'h3,1'b0,1'b0,1'b0,1'b0,8'b1101_0000};
    vecs[4]  = '{1'b0,1'b0,4'h3,4'h3,4'h3,1'b1,1'b1,1'b0,1'b0,8'b1101_0000};
    vecs[5]  = '{1'b0,1'b1,4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,1'b0,8'b0000_0111};
    vecs[6]  = '{1'b1,1'b0,4'h3,4'h3,4'h0,1'b1,1'b0,1'b1,1'b1,8'b1111_1000};
    vecs[7]  = '{1'b0,1'b1,4'h0,4'h0,4'h0,1'b0,1'b0,1'b1,1'b0,8'b1111_1000};
    vecs[8]  = '{1'b0,1'b0,4'h0,4'h0,4'h0,1'b0,1'b0,1'b0,1'b1,8'b1101_1000};
    vecs[9]  = '{1'b1,1'b1,4'h3,4'h3,4'h0,1'b1,1'b0,1'b0,1'b0,8'b0000_0111};
    vecs[10] = '{1'b1,1'b0,4'h5,4'h0,4'h5,1'b0,1'b1,1'b0,1'b1,8'b0001_1000};

    // reset values
    #2;
    check("reset_ctrl", 32'(ctrl_vec()), 32'b1101_0000);
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_stall", 32'(bus.stall_cycles), 32'd0);

    // single-cycle RUN decisions from reset
    for (int i = 0; i < 11; i++) begin
      do_reset();
      bus.idex_memRead = vecs[i].mem_read;
      bus.idex_mulDiv  = vecs[i].mul_div;
      bus.idex_regDes  = vecs[i].reg_des;
      bus.ifid_rs1     = vecs[i].rs1;
      bus.ifid_rs2     = vecs[i].rs2;
      bus.ifid_useRs1  = vecs[i].use1;
      bus.ifid_useRs2  = vecs[i].use2;
      bus.branch_taken = vecs[i].branch;
      bus.ifid_halt    = vecs[i].halt;
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl_vec()), 32'(vecs[i].exp));
    end

    // load-use for one cycle: exactly one bubble
    do_reset();
    set_load_use();
    @(negedge clk);
    check("lu_stall_pc", 32'(bus.pc_write), 32'd0);
    step();
    clear_inputs();
    @(negedge clk);
    check("lu_after_ctrl", 32'(ctrl_vec()), 32'b1101_0000);
    check("lu_stall_cnt", 32'(bus.stall_cycles), 32'd1);

    // back-to-back mul/div, branch ignored while waiting
    do_reset();
    bus.idex_mulDiv = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.branch_taken = (k == 1) || (k == 5);
      @(negedge clk);
      check($sformatf("md%0d_start", k), 32'(bus.md_start), 32'((k == 0) || (k == 4)));
      check($sformatf("md%0d_pc", k), 32'(bus.pc_write), 32'((k == 3) || (k == 7)));
      check($sformatf("md%0d_exflush", k), 32'(bus.exmem_flush), 32'((k != 3) && (k != 7)));
      check($sformatf("md%0d_busy", k), 32'(bus.md_busy), 32'd1);
      check($sformatf("md%0d_ifflush", k), 32'(bus.ifid_flush), 32'd0);
      step();
      if (k == 3) check("md_stall_3", 32'(bus.stall_cycles), 32'd3);
      if (k == 4) bus.idex_mulDiv = 1'b0;
    end
    bus.branch_taken = 1'b0;
    check("md_stall_6", 32'(bus.stall_cycles), 32'd6);
    @(negedge clk);
    check("md_done_busy", 32'(bus.md_busy), 32'd0);

    // asynchronous reset in the middle of MD_WAIT
    do_reset();
    set_load_use();
    step();
    clear_inputs();
    bus.idex_mulDiv = 1'b1;
    step();
    bus.idex_mulDiv = 1'b0;
    step();
    @(negedge clk);
    check("mdrst_busy_before", 32'(bus.md_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mdrst_pc", 32'(bus.pc_write), 32'd1);
    check("mdrst_busy", 32'(bus.md_busy), 32'd0);
    check("mdrst_start", 32'(bus.md_start), 32'd0);
    check("mdrst_stall", 32'(bus.stall_cycles), 32'd0);
    check("mdrst_halted", 32'(bus.halted), 32'd0);
    step();
    rst = 1'b0;

    // branch squashes a simultaneous halt
    do_reset();
    bus.branch_taken = 1'b1;
    bus.ifid_halt    = 1'b1;
    step();
    clear_inputs();
    @(negedge clk);
    check("brhalt_halted", 32'(bus.halted), 32'd0);
    check("brhalt_pc", 32'(bus.pc_write), 32'd1);

    // load-use with halt: stall first, halt afterwards
    do_reset();
    set_load_use();
    bus.ifid_halt = 1'b1;
    step();
    bus.idex_memRead = 1'b0;
    @(negedge clk);
    check("luhalt_halted0", 32'(bus.halted), 32'd0);
    check("luhalt_ctrl", 32'(ctrl_vec()), 32'b1101_1000);
    step();
    clear_inputs();
    check("luhalt_halted1", 32'(bus.halted), 32'd1);
    check("luhalt_stall", 32'(bus.stall_cycles), 32'd1);

    // halt holds forever, not counted, ignores everything until reset
    do_reset();
    bus.ifid_halt = 1'b1;
    @(negedge clk);
    check("halt_entry_halted", 32'(bus.halted), 32'd0);
    step();
    clear_inputs();
    for (int k = 0; k < 12; k++) begin
      bus.idex_mulDiv  = (k == 4);
      bus.branch_taken = (k == 6);
      @(negedge clk);
      check($sformatf("halt%0d_halted", k), 32'(bus.halted), 32'd1);
      check($sformatf("halt%0d_ctrl", k), 32'(ctrl_vec()), 32'b0001_1000);
      step();
    end
    clear_inputs();
    check("halt_stall", 32'(bus.stall_cycles), 32'd0);
    rst = 1'b1;
    #1;
    check("halt_rst_halted", 32'(bus.halted), 32'd0);
    check("halt_rst_pc", 32'(bus.pc_write), 32'd1);
    step();
    rst = 1'b0;

    // saturation: 20 stall cycles
    do_reset();
    set_load_use();
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 14) check("sat_cnt4_15", 32'(bus4.stall_cycles), 32'd15);
    end
    clear_inputs();
    check("sat_cnt4_hold", 32'(bus4.stall_cycles), 32'hF);
    check("sat_cnt16", 32'(bus.stall_cycles), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
